rgb_yuv_encoder: RTL and testbench

RGB_YUV_ENCODER -- requirements
Module: rgb_yuv_encoder

---
 rtl/rgb_yuv_encoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_rgb_yuv_encoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_yuv_encoder.sv
// rgb_yuv_encoder: reads a packed RGB frame from SRAM and writes planar Y, U, V
// (4:2:2) back to SRAM, one group of four pixels at a time.
// Optional feature macro: RGB_YUV_AVG_DECIMATION_EN. When it is defined, each
// pair's U/V is the rounded average of both pixels. When it is undefined, U/V
// come from the even pixel only.
// Three multipliers are shared by a step-indexed schedule. Each slot of the
// schedule evaluates one colour channel for one pixel. Words still in flight
// from SRAM are taken straight off the read bus, so arithmetic can begin before
// the last read returns.
module rgb_yuv_encoder #(
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter logic [17:0] Y_BASE     = 18'd0,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter int          NUM_PIXELS = 76800
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Done
);

  localparam logic [17:0] LAST_GROUP = 18'(NUM_PIXELS / 4 - 1);
`ifdef RGB_YUV_AVG_DECIMATION_EN
  localparam logic [3:0] CALC_LAST = 4'd11;
`else
  localparam logic [3:0] CALC_LAST = 4'd8;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CALC, S_WR_Y0, S_WR_Y1, S_WR_U, S_WR_V, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    A_NONE, A_Y, A_HOLD, A_UA, A_UB, A_VA, A_VB
  } action_t;

  typedef enum logic [1:0] {CH_Y, CH_U, CH_V} chan_t;

  state_t         state, next_state;
  logic [3:0]     step;
  logic [17:0]    g;
  logic [15:0]    w_reg [6];
  logic [15:0]    w_cur [6];
  logic [7:0]     y_res [4];
  logic [7:0]     ua, ub, va, vb;
`ifdef RGB_YUV_AVG_DECIMATION_EN
  logic [7:0]     hold;
`endif
  action_t        op_action;
  logic [1:0]     op_pix;
  chan_t          op_chan;
  logic [7:0]     pix_r, pix_g, pix_b;
  logic signed [31:0] r_ext, g_ext, b_ext;
  logic signed [31:0] coef_r, coef_g, coef_b, offset;
  logic signed [31:0] prod_r, prod_g, prod_b, sum, shifted;
  logic [7:0]     clipped, decimated;
  logic [17:0]    group_x6, read_offset;

  // State register; an asynchronous reset aborts any frame in progress.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Step within the current group; it restarts at 0 each time S_READ is entered.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                                                       step <= 4'd0;
    else if (state == S_IDLE || state == S_DONE || state == S_WR_V) step <= 4'd0;
    else                                                             step <= step + 4'd1;
  end

  // Group counter: it advances after each V write and wraps when the frame ends.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) g <= '0;
    else if (state == S_WR_V) g <= (g == LAST_GROUP) ? '0 : g + 18'd1;
  end

  assign group_x6    = (g << 2) + (g << 1);
  assign read_offset = (step > 4'd5) ? 18'd5 : {14'd0, step};

  // Next-state logic and SRAM/Done drive decoded from the current state.
  always_comb begin
    next_state      = state;
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    Done            = 1'b0;
    case (state)
      S_IDLE:  if (Enable) next_state = S_READ;
      S_READ: begin
        SRAM_address = RGB_BASE + group_x6 + read_offset;
        if (step == 4'd7) next_state = S_CALC;
      end
      S_CALC:  if (step == CALC_LAST) next_state = S_WR_Y0;
      S_WR_Y0: begin
        SRAM_address    = Y_BASE + (g << 1);
        SRAM_write_data = {y_res[0], y_res[1]};
        SRAM_we_n       = 1'b0;
        next_state      = S_WR_Y1;
      end
      S_WR_Y1: begin
        SRAM_address    = Y_BASE + (g << 1) + 18'd1;
        SRAM_write_data = {y_res[2], y_res[3]};
        SRAM_we_n       = 1'b0;
        next_state      = S_WR_U;
      end
      S_WR_U: begin
        SRAM_address    = U_BASE + g;
        SRAM_write_data = {ua, ub};
        SRAM_we_n       = 1'b0;
        next_state      = S_WR_V;
      end
      S_WR_V: begin
        SRAM_address    = V_BASE + g;
        SRAM_write_data = {va, vb};
        SRAM_we_n       = 1'b0;
        next_state      = (g == LAST_GROUP) ? S_DONE : S_READ;
      end
      S_DONE: begin
        Done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Capture each RGB word during the cycle in which it is valid on the read bus.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 6; i++) w_reg[i] <= '0;
    end else if (state == S_READ && step >= 4'd2) begin
      w_reg[step - 4'd2] <= SRAM_read_data;
    end
  end

  // Operand view: a word arriving this cycle is taken straight from the bus.
  always_comb begin
    for (int i = 0; i < 6; i++)
      w_cur[i] = (state == S_READ && step == 4'(i + 2)) ? SRAM_read_data : w_reg[i];
  end

  // Multiplier schedule: for each step, select the pixel, the channel and the destination of the result.
  always_comb begin
    op_action = A_NONE;
    op_pix    = 2'd0;
    op_chan   = CH_Y;
    if (state != S_IDLE && state != S_DONE) begin
      case (step)
        4'd3: begin op_action = A_Y; op_pix = 2'd0; end
        4'd4: begin op_action = A_Y; op_pix = 2'd1; end
        4'd6: begin op_action = A_Y; op_pix = 2'd2; end
        4'd7: begin op_action = A_Y; op_pix = 2'd3; end
`ifdef RGB_YUV_AVG_DECIMATION_EN
        4'd5:  begin op_action = A_HOLD; op_pix = 2'd0; op_chan = CH_U; end
        4'd8:  begin op_action = A_UA;   op_pix = 2'd1; op_chan = CH_U; end
        4'd9:  begin op_action = A_HOLD; op_pix = 2'd2; op_chan = CH_U; end
        4'd10: begin op_action = A_UB;   op_pix = 2'd3; op_chan = CH_U; end
        4'd11: begin op_action = A_HOLD; op_pix = 2'd0; op_chan = CH_V; end
        4'd12: begin op_action = A_VA;   op_pix = 2'd1; op_chan = CH_V; end
        4'd13: begin op_action = A_HOLD; op_pix = 2'd2; op_chan = CH_V; end
        4'd14: begin op_action = A_VB;   op_pix = 2'd3; op_chan = CH_V; end
`else
        4'd5:  begin op_action = A_UA; op_pix = 2'd0; op_chan = CH_U; end
        4'd8:  begin op_action = A_VA; op_pix = 2'd0; op_chan = CH_V; end
        4'd9:  begin op_action = A_UB; op_pix = 2'd2; op_chan = CH_U; end
        4'd10: begin op_action = A_VB; op_pix = 2'd2; op_chan = CH_V; end
`endif
        default: op_action = A_NONE;
      endcase
    end
  end

  // Unpack the selected pixel's R, G, B bytes from the group's six words.
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (op_pix)
      2'd0: begin pix_r = w_cur[0][15:8]; pix_g = w_cur[0][7:0];  pix_b = w_cur[1][15:8]; end
      2'd1: begin pix_r = w_cur[1][7:0];  pix_g = w_cur[2][15:8]; pix_b = w_cur[2][7:0];  end
      2'd2: begin pix_r = w_cur[3][15:8]; pix_g = w_cur[3][7:0];  pix_b = w_cur[4][15:8]; end
      default: begin pix_r = w_cur[4][7:0]; pix_g = w_cur[5][15:8]; pix_b = w_cur[5][7:0]; end
    endcase
  end

  // Coefficients and offset for the selected channel.
  always_comb begin
    coef_r = 32'sd16829;
    coef_g = 32'sd33039;
    coef_b = 32'sd6416;
    offset = 32'sd1048576;
    case (op_chan)
      CH_U: begin
        coef_r = -32'sd9714;  coef_g = -32'sd19070; coef_b = 32'sd28784;  offset = 32'sd8388608;
      end
      CH_V: begin
        coef_r = 32'sd28784;  coef_g = -32'sd24103; coef_b = -32'sd4681;  offset = 32'sd8388608;
      end
      default: ;
    endcase
  end

  assign r_ext   = {24'd0, pix_r};
  assign g_ext   = {24'd0, pix_g};
  assign b_ext   = {24'd0, pix_b};
  assign prod_r  = r_ext * coef_r;
  assign prod_g  = g_ext * coef_g;
  assign prod_b  = b_ext * coef_b;
  assign sum     = prod_r + prod_g + prod_b + offset + 32'sd32768;
  assign shifted = sum >>> 16;

  // Clip to 0..255, then form the chroma value for the pair.
  always_comb begin
    if (shifted < 32'sd0)        clipped = 8'd0;
    else if (shifted > 32'sd255) clipped = 8'd255;
    else                         clipped = shifted[7:0];
`ifdef RGB_YUV_AVG_DECIMATION_EN
    decimated = 8'(({1'b0, hold} + {1'b0, clipped} + 9'd1) >> 1);
`else
    decimated = clipped;
`endif
  end

  // Store each scheduled result in the register that feeds its SRAM write.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) y_res[i] <= '0;
      ua <= '0;
      ub <= '0;
      va <= '0;
      vb <= '0;
`ifdef RGB_YUV_AVG_DECIMATION_EN
      hold <= '0;
`endif
    end else begin
      case (op_action)
        A_Y:    y_res[op_pix] <= clipped;
`ifdef RGB_YUV_AVG_DECIMATION_EN
        A_HOLD: hold <= clipped;
`endif
        A_UA:   ua <= decimated;
        A_UB:   ub <= decimated;
        A_VA:   va <= decimated;
        A_VB:   vb <= decimated;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_yuv_encoder.sv
// tb_rgb_yuv_encoder: drives rgb_yuv_encoder against an SRAM model and checks
// the frames it writes against an arithmetic YUV reference.
// Honours RGB_YUV_AVG_DECIMATION_EN in the same way as the design.
module tb_rgb_yuv_encoder;

  localparam int NUM_PIX    = 16;
  localparam int NUM_GROUPS = NUM_PIX / 4;
  localparam int RGB_BASE   = 146944;
  localparam int Y_BASE     = 0;
  localparam int U_BASE     = 38400;
  localparam int V_BASE     = 57600;
`ifdef RGB_YUV_AVG_DECIMATION_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        Reset, Enable;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data = '0;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n, Done;

  logic        loadEn = 1'b0;
  logic [17:0] loadAddr = '0;
  logic [15:0] loadData = '0;
  logic [15:0] mem [0:262143];
  logic [15:0] rdPipe = '0;
  int          writeCount = 0;
  int          doneCount = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  int          pixR [NUM_PIX];
  int          pixG [NUM_PIX];
  int          pixB [NUM_PIX];

  rgb_yuv_encoder #(
    .RGB_BASE(18'(RGB_BASE)), .Y_BASE(18'(Y_BASE)), .U_BASE(18'(U_BASE)),
    .V_BASE(18'(V_BASE)), .NUM_PIXELS(NUM_PIX)
  ) dut (
    .Clock(clock), .Reset(Reset), .Enable(Enable),
    .SRAM_address(SRAM_address), .SRAM_read_data(SRAM_read_data),
    .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n), .Done(Done)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // SRAM model with a two-cycle read latency, plus write and Done counters.
  always @(posedge clock) begin
    if (loadEn) mem[loadAddr] <= loadData;
    else if (!SRAM_we_n) mem[SRAM_address] <= SRAM_write_data;
    rdPipe         <= mem[SRAM_address];
    SRAM_read_data <= rdPipe;
    if (!SRAM_we_n) writeCount <= writeCount + 1;
    if (Done)       doneCount  <= doneCount + 1;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int clip8(int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic int lumaOf(int p);
    return clip8((16829 * pixR[p] + 33039 * pixG[p] + 6416 * pixB[p] + 1048576 + 32768) >>> 16);
  endfunction

  function automatic int chromaUOf(int p);
    return clip8((-9714 * pixR[p] - 19070 * pixG[p] + 28784 * pixB[p] + 8388608 + 32768) >>> 16);
  endfunction

  function automatic int chromaVOf(int p);
    return clip8((28784 * pixR[p] - 24103 * pixG[p] - 4681 * pixB[p] + 8388608 + 32768) >>> 16);
  endfunction

  function automatic int pairChroma(int even, int odd);
    return AVG_EN ? ((even + odd + 1) >> 1) : even;
  endfunction

  task automatic checkOutput(string tag, int observed, int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Fill the pixel arrays with a pattern, load them into SRAM and poison the destination words.
  task automatic applyStimulus(int mode);
    for (int p = 0; p < NUM_PIX; p++) begin
      case (mode)
        1: begin pixR[p] = 0;   pixG[p] = 0;   pixB[p] = 0;   end
        2: begin pixR[p] = 255; pixG[p] = 255; pixB[p] = 255; end
        3: begin pixR[p] = 255; pixG[p] = 0;   pixB[p] = 0;   end
        4: begin pixR[p] = (p % 2 == 0) ? 255 : 0; pixG[p] = 0; pixB[p] = 0; end
        default: begin
          pixR[p] = int'($urandom_range(255, 0));
          pixG[p] = int'($urandom_range(255, 0));
          pixB[p] = int'($urandom_range(255, 0));
        end
      endcase
    end
    for (int k = 0; k < NUM_PIX / 2; k++) begin
      @(negedge clock); loadEn = 1'b1; loadAddr = 18'(RGB_BASE + 3 * k);
      loadData = 16'((pixR[2*k] << 8) | pixG[2*k]);
      @(negedge clock); loadAddr = 18'(RGB_BASE + 3 * k + 1);
      loadData = 16'((pixB[2*k] << 8) | pixR[2*k+1]);
      @(negedge clock); loadAddr = 18'(RGB_BASE + 3 * k + 2);
      loadData = 16'((pixG[2*k+1] << 8) | pixB[2*k+1]);
    end
    for (int g = 0; g < NUM_GROUPS; g++) begin
      @(negedge clock); loadAddr = 18'(Y_BASE + 2 * g);     loadData = 16'hDEAD;
      @(negedge clock); loadAddr = 18'(Y_BASE + 2 * g + 1); loadData = 16'hDEAD;
      @(negedge clock); loadAddr = 18'(U_BASE + g);         loadData = 16'hDEAD;
      @(negedge clock); loadAddr = 18'(V_BASE + g);         loadData = 16'hDEAD;
    end
    @(negedge clock); loadEn = 1'b0;
  endtask

  // Compare every destination word against the reference model.
  task automatic checkFrame(string label);
    for (int g = 0; g < NUM_GROUPS; g++) begin
      int p = 4 * g;
      checkOutput($sformatf("%s_y%0d", label, 2 * g), int'(mem[Y_BASE + 2 * g]),
                  (lumaOf(p) << 8) | lumaOf(p + 1));
      checkOutput($sformatf("%s_y%0d", label, 2 * g + 1), int'(mem[Y_BASE + 2 * g + 1]),
                  (lumaOf(p + 2) << 8) | lumaOf(p + 3));
      checkOutput($sformatf("%s_u%0d", label, g), int'(mem[U_BASE + g]),
                  (pairChroma(chromaUOf(p), chromaUOf(p + 1)) << 8) |
                   pairChroma(chromaUOf(p + 2), chromaUOf(p + 3)));
      checkOutput($sformatf("%s_v%0d", label, g), int'(mem[V_BASE + g]),
                  (pairChroma(chromaVOf(p), chromaVOf(p + 1)) << 8) |
                   pairChroma(chromaVOf(p + 2), chromaVOf(p + 3)));
    end
  endtask

  // Compare every destination word against fixed known-answer words.
  task automatic checkConst(string label, int yWord, int uWord, int vWord);
    for (int g = 0; g < NUM_GROUPS; g++) begin
      checkOutput($sformatf("%s_kY%0d", label, 2 * g), int'(mem[Y_BASE + 2 * g]), yWord);
      checkOutput($sformatf("%s_kY%0d", label, 2 * g + 1), int'(mem[Y_BASE + 2 * g + 1]), yWord);
      checkOutput($sformatf("%s_kU%0d", label, g), int'(mem[U_BASE + g]), uWord);
      checkOutput($sformatf("%s_kV%0d", label, g), int'(mem[V_BASE + g]), vWord);
    end
  endtask

  // Pulse Enable, wait (bounded) for Done and check frame-level behaviour.
  task automatic runFrame(string label);
    int startDone, startWrites, cycles, firstAddr;
    bit seen;
    startDone   = doneCount;
    startWrites = writeCount;
    seen        = 1'b0;
    firstAddr   = -1;
    @(negedge clock); Enable = 1'b1;
    @(negedge clock); Enable = 1'b0;
    cycles = 1;
    while (doneCount == startDone && cycles < 1000) begin
      if (!seen && !SRAM_we_n) begin seen = 1'b1; firstAddr = int'(SRAM_address); end
      @(negedge clock);
      cycles++;
    end
    checkOutput({label, "_done_seen"}, int'(doneCount != startDone), 1);
    checkOutput({label, "_cycle_budget"}, int'(cycles <= NUM_GROUPS * 16 + 4), 1);
    checkOutput({label, "_first_write"}, firstAddr, Y_BASE);
    repeat (3) @(negedge clock);
    checkOutput({label, "_done_once"}, doneCount - startDone, 1);
    checkOutput({label, "_writes"}, writeCount - startWrites, 4 * NUM_GROUPS);
  endtask

  initial begin
    int startW, startD, waitCycles, pulses;
    bit checkedFirst;
    Reset  = 1'b1;
    Enable = 1'b0;
    #2;
    checkOutput("reset_we_n", int'(SRAM_we_n), 1);
    checkOutput("reset_addr", int'(SRAM_address), 0);
    checkOutput("reset_wdata", int'(SRAM_write_data), 0);
    checkOutput("reset_done", int'(Done), 0);
    repeat (3) @(negedge clock);
    Reset = 1'b0;

    applyStimulus(1); runFrame("black"); checkFrame("black");
    checkConst("black", 16'h1010, 16'h8080, 16'h8080);
    applyStimulus(2); runFrame("white"); checkFrame("white");
    checkConst("white", 16'hEBEB, 16'h8080, 16'h8080);
    applyStimulus(3); runFrame("red"); checkFrame("red");
    checkConst("red", 16'h5151, 16'h5A5A, 16'hF0F0);
    applyStimulus(4); runFrame("alt"); checkFrame("alt");
    checkConst("alt", 16'h5110, AVG_EN ? 16'h6D6D : 16'h5A5A, AVG_EN ? 16'hB8B8 : 16'hF0F0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0);
      runFrame($sformatf("rand%0d", i));
      checkFrame($sformatf("rand%0d", i));
    end

    // Abort during group 2's U write.
    applyStimulus(0);
    startW = writeCount;
    startD = doneCount;
    @(negedge clock); Enable = 1'b1;
    @(negedge clock); Enable = 1'b0;
    waitCycles = 0;
    while (!(SRAM_we_n == 1'b0 && int'(SRAM_address) == U_BASE + 2) && waitCycles < 1000) begin
      @(negedge clock);
      waitCycles++;
    end
    checkOutput("abort_target_reached", int'(waitCycles < 1000), 1);
    #1 Reset = 1'b1;
    #1;
    checkOutput("abort_we_n", int'(SRAM_we_n), 1);
    checkOutput("abort_addr", int'(SRAM_address), 0);
    checkOutput("abort_wdata", int'(SRAM_write_data), 0);
    @(negedge clock); Reset = 1'b0;
    repeat (100) @(negedge clock);
    checkOutput("abort_writes", writeCount - startW, 10);
    checkOutput("abort_no_done", doneCount - startD, 0);
    checkOutput("abort_y_group2", int'(mem[Y_BASE + 4]), (lumaOf(8) << 8) | lumaOf(9));
    checkOutput("abort_u_untouched", int'(mem[U_BASE + 2]), 16'hDEAD);
    checkOutput("abort_v_untouched", int'(mem[V_BASE + 2]), 16'hDEAD);
    applyStimulus(0); runFrame("restart"); checkFrame("restart");

    // Enable held high for two back-to-back frames.
    applyStimulus(0);
    startW       = writeCount;
    startD       = doneCount;
    pulses       = 0;
    waitCycles   = 0;
    checkedFirst = 1'b0;
    @(negedge clock); Enable = 1'b1;
    while (doneCount - startD < 2 && waitCycles < 2000) begin
      @(negedge clock);
      waitCycles++;
      if (Done) pulses++;
      if (doneCount - startD == 1 && !checkedFirst) begin
        checkedFirst = 1'b1;
        checkFrame("held1");
      end
    end
    Enable = 1'b0;
    repeat (20) @(negedge clock);
    checkOutput("held_done_count", doneCount - startD, 2);
    checkOutput("held_done_pulses", pulses, 2);
    checkOutput("held_writes", writeCount - startW, 8 * NUM_GROUPS);
    checkFrame("held2");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
